// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Sequencing stage wrapped around a 4-bit combinational ALU
// (add/sub/and/or/not). It accepts one encoded instruction at a time over a
// valid/ready handshake and walks it through IDLE -> ISSUE -> WB:
//   ISSUE : operands are read from the 4 x W register file and driven onto the
//           ALU select/operand buses; at the closing edge the ALU result and
//           carry-out are sampled into res and the status flags.
//   WB    : res_valid (or err for a reserved opcode) pulses for this cycle;
//           the register file is written at the closing edge of WB, so the
//           debug read port shows the new value from the cycle after WB.
//
// Instruction format: [8:6]=op, [5:4]=rd, [3:2]=ra, [1:0]=rb, LDI imm=[3:0]
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 101 LDI, 11x reserved
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   instr_valid/ready   instruction handshake, instr = encoded instruction
//   f2,f1,f0, a, b      ALU select and operands (registered)
//   fBit, cout          ALU result and adder carry-out
//   res_valid, res      writeback pulse and last written value
//   c_flag, z_flag      carry (SUB: 1 = no borrow) and zero status
//   err                 one-cycle pulse for a reserved opcode
//   dbg_sel, dbg_data   combinational register file read port
//   v_flag              signed overflow of ADD/SUB (only with ALU_OVF_FLAG_EN)
//
// Optional feature macro: ALU_OVF_FLAG_EN
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int NREG = 4,
    parameter int W    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [8:0]   instr,
    output logic         f2,
    output logic         f1,
    output logic         f0,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    input  logic [W-1:0] fBit,
    input  logic         cout,
    output logic         res_valid,
    output logic [W-1:0] res,
    output logic         c_flag,
    output logic         z_flag,
    output logic         err,
`ifdef ALU_OVF_FLAG_EN
    output logic         v_flag,
`endif
    input  logic [1:0]   dbg_sel,
    output logic [W-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WB = 2'd2} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;

    state_t         state_q, state_d;
    logic [8:0]     instr_q, instr_d;
    logic [2:0]     f_q, f_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic           c_q, c_d;
    logic           z_q, z_d;
    logic           res_valid_q, res_valid_d;
    logic           err_q, err_d;
    logic [W-1:0]   rf_q [NREG];
    logic [W-1:0]   rf_d [NREG];
`ifdef ALU_OVF_FLAG_EN
    logic           v_q, v_d;
    logic           b_eff_msb;
`endif

    logic [2:0] op_in;
    logic [2:0] op_q;
    logic [1:0] rd_q;

    assign op_in = instr[8:6];
    assign op_q  = instr_q[8:6];
    assign rd_q  = instr_q[5:4];

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        f_d         = f_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        c_d         = c_q;
        z_d         = z_q;
        res_valid_d = 1'b0;
        err_d       = 1'b0;
        rf_d        = rf_q;
`ifdef ALU_OVF_FLAG_EN
        v_d         = v_q;
        // SUB is a + ~b + 1 inside the ALU, so the effective b sign is inverted.
        b_eff_msb   = (op_q == OP_SUB) ? ~b_q[W-1] : b_q[W-1];
`endif

        case (state_q)
            IDLE: begin
                f_d = 3'b000;
                a_d = '0;
                b_d = '0;
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ISSUE;
                    // Operands are captured here so they are stable on the
                    // ALU buses for the whole ISSUE cycle. LDI and reserved
                    // ops leave the buses idle.
                    if (op_in <= OP_NOT) begin
                        f_d = op_in;
                        a_d = rf_q[instr[3:2]];
                        b_d = (op_in == OP_NOT) ? '0 : rf_q[instr[1:0]];
                    end
                end
            end

            ISSUE: begin
                state_d = WB;
                f_d     = 3'b000;
                a_d     = '0;
                b_d     = '0;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        res_d       = fBit;
                        c_d         = cout;
                        z_d         = (fBit == '0);
                        res_valid_d = 1'b1;
`ifdef ALU_OVF_FLAG_EN
                        v_d = (a_q[W-1] == b_eff_msb) && (fBit[W-1] != a_q[W-1]);
`endif
                    end
                    OP_AND, OP_OR, OP_NOT: begin
                        res_d       = fBit;
                        z_d         = (fBit == '0);
                        res_valid_d = 1'b1;
                    end
                    OP_LDI: begin
                        res_d       = instr_q[3:0];
                        z_d         = (instr_q[3:0] == 4'd0);
                        res_valid_d = 1'b1;
                    end
                    default: err_d = 1'b1;
                endcase
            end

            WB: begin
                state_d = IDLE;
                // res already holds the value to write for every legal op.
                if (op_q <= OP_LDI) begin
                    rf_d[rd_q] = res_q;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            f_q         <= 3'b000;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
`ifdef ALU_OVF_FLAG_EN
            v_q         <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            f_q         <= f_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            c_q         <= c_d;
            z_q         <= z_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            rf_q        <= rf_d;
`ifdef ALU_OVF_FLAG_EN
            v_q         <= v_d;
`endif
        end
    end

    assign instr_ready  = (state_q == IDLE);
    assign {f2, f1, f0} = f_q;
    assign a            = a_q;
    assign b            = b_q;
    assign res_valid    = res_valid_q;
    assign res          = res_q;
    assign c_flag       = c_q;
    assign z_flag       = z_q;
    assign err          = err_q;
    assign dbg_data     = rf_q[dbg_sel];
`ifdef ALU_OVF_FLAG_EN
    assign v_flag       = v_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [8:0] instr = '0;
    logic       f2, f1, f0;
    logic [3:0] a, b, fBit;
    logic       cout;
    logic       res_valid;
    logic [3:0] res;
    logic       c_flag, z_flag, err;
    logic [1:0] dbg_sel = '0;
    logic [3:0] dbg_data;
`ifdef ALU_OVF_FLAG_EN
    logic       v_flag;
`endif

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NREG(4), .W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .f2(f2), .f1(f1), .f0(f0), .a(a), .b(b), .fBit(fBit), .cout(cout),
        .res_valid(res_valid), .res(res), .c_flag(c_flag), .z_flag(z_flag), .err(err),
`ifdef ALU_OVF_FLAG_EN
        .v_flag(v_flag),
`endif
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // The wrapped 4-bit ALU.
    logic [4:0] alu_t;
    always_comb begin
        alu_t = '0;
        case ({f2, f1, f0})
            3'b000:  alu_t = {1'b0, a} + {1'b0, b};
            3'b001:  alu_t = {1'b0, a} + {1'b0, ~b} + 5'd1;
            3'b010:  alu_t = {1'b0, a & b};
            3'b011:  alu_t = {1'b0, a | b};
            3'b100:  alu_t = {1'b0, ~a};
            default: alu_t = '0;
        endcase
    end
    assign fBit = alu_t[3:0];
    assign cout = alu_t[4];

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state.
    logic [3:0] m_rf [4];
    logic       m_c, m_z;
    logic [3:0] m_res;
`ifdef ALU_OVF_FLAG_EN
    logic       m_v;
    logic       o_v;
`endif
    logic [2:0] exp_f;
    logic [3:0] exp_a, exp_b, exp_res;
    logic       exp_rv, exp_err;

    // Observations from one instruction.
    logic [2:0] o_f;
    logic [3:0] o_a, o_b, o_res;
    logic       o_ready_issue, o_ready_wb, o_ready_idle;
    logic       o_rv, o_c, o_z, o_err, o_rv_after, o_err_after;

    function automatic int sx(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
        m_c = 1'b0; m_z = 1'b0; m_res = '0;
`ifdef ALU_OVF_FLAG_EN
        m_v = 1'b0;
`endif
    endtask

    // Architectural model: expected bus values and effect of one instruction.
    task automatic model_exec(input logic [8:0] ins);
        int op, rd, va, vb, r;
        op = int'(ins[8:6]); rd = int'(ins[5:4]);
        va = int'(m_rf[ins[3:2]]); vb = int'(m_rf[ins[1:0]]);
        exp_f = 3'b000; exp_a = '0; exp_b = '0; exp_rv = 1'b1; exp_err = 1'b0; r = 0;
        case (op)
            0: begin
                exp_a = 4'(va); exp_b = 4'(vb); r = (va + vb) % 16; m_c = (va + vb) > 15;
`ifdef ALU_OVF_FLAG_EN
                m_v = (sx(va) + sx(vb) > 7) || (sx(va) + sx(vb) < -8);
`endif
            end
            1: begin
                exp_f = 3'b001; exp_a = 4'(va); exp_b = 4'(vb); r = (va - vb + 16) % 16; m_c = (va >= vb);
`ifdef ALU_OVF_FLAG_EN
                m_v = (sx(va) - sx(vb) > 7) || (sx(va) - sx(vb) < -8);
`endif
            end
            2: begin exp_f = 3'b010; exp_a = 4'(va); exp_b = 4'(vb); r = va & vb; end
            3: begin exp_f = 3'b011; exp_a = 4'(va); exp_b = 4'(vb); r = va | vb; end
            4: begin exp_f = 3'b100; exp_a = 4'(va); r = 15 - va; end
            5: r = int'(ins[3:0]);
            default: begin exp_rv = 1'b0; exp_err = 1'b1; end
        endcase
        if (!exp_err) begin
            m_rf[rd] = 4'(r); m_res = 4'(r); m_z = (r == 0);
        end
        exp_res = m_res;
    endtask

    // Drives one instruction from an IDLE cycle and records what the DUT shows
    // in ISSUE, WB and the following IDLE cycle. Ends #1 after a rising edge.
    task automatic run_instr(input logic [8:0] ins);
        instr_valid = 1'b1; instr = ins;
        @(posedge clk); #1;
        o_f = {f2, f1, f0}; o_a = a; o_b = b; o_ready_issue = instr_ready;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        o_rv = res_valid; o_res = res; o_c = c_flag; o_z = z_flag; o_err = err; o_ready_wb = instr_ready;
`ifdef ALU_OVF_FLAG_EN
        o_v = v_flag;
`endif
        @(posedge clk); #1;
        o_ready_idle = instr_ready; o_rv_after = res_valid; o_err_after = err;
    endtask

    task automatic issue(input logic [8:0] ins);
        model_exec(ins);
        run_instr(ins);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        n_cmp++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
        n_cmp++; if ({f2, f1, f0} !== 3'b000) begin n_fail++; $display("FAIL rst_f got=%b exp=000", {f2, f1, f0}); end
        n_cmp++; if ({a, b} !== 8'h00) begin n_fail++; $display("FAIL rst_ab got=%h exp=00", {a, b}); end
        n_cmp++; if ({c_flag, z_flag, res_valid, err} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags got=%b exp=0000", {c_flag, z_flag, res_valid, err}); end
        n_cmp++; if (res !== 4'd0) begin n_fail++; $display("FAIL rst_res got=%0d exp=0", res); end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            n_cmp++; if (dbg_data !== 4'd0) begin n_fail++; $display("FAIL rst_reg%0d got=%0d exp=0", i, dbg_data); end
        end
    endtask

    task automatic test_arith();
        issue(9'b101_00_0110);   // LDI r0=6
        issue(9'b101_01_0100);   // LDI r1=4
        issue(9'b000_10_00_01);  // ADD r2=r0+r1
        n_cmp++; if (o_f !== 3'b000 || o_a !== 4'd6 || o_b !== 4'd4) begin n_fail++; $display("FAIL add_bus got f=%b a=%0d b=%0d exp f=000 a=6 b=4", o_f, o_a, o_b); end
        n_cmp++; if (o_res !== 4'd10 || o_rv !== 1'b1) begin n_fail++; $display("FAIL add_res got=%0d rv=%b exp=10 rv=1", o_res, o_rv); end
        n_cmp++; if (o_c !== 1'b0 || o_z !== 1'b0) begin n_fail++; $display("FAIL add_flags got c=%b z=%b exp c=0 z=0", o_c, o_z); end
        n_cmp++; if ({o_ready_issue, o_ready_wb, o_ready_idle, o_rv_after} !== 4'b0010) begin n_fail++; $display("FAIL add_timing got=%b exp=0010", {o_ready_issue, o_ready_wb, o_ready_idle, o_rv_after}); end
        dbg_sel = 2'd2; #1;
        n_cmp++; if (dbg_data !== 4'd10) begin n_fail++; $display("FAIL add_wb_reg got=%0d exp=10", dbg_data); end
        issue(9'b001_11_00_01);  // SUB r3=r0-r1
        n_cmp++; if (o_f !== 3'b001 || o_res !== 4'd2 || o_c !== 1'b1) begin n_fail++; $display("FAIL sub1 got f=%b res=%0d c=%b exp f=001 res=2 c=1", o_f, o_res, o_c); end
        issue(9'b001_11_01_00);  // SUB r3=r1-r0
        n_cmp++; if (o_res !== 4'd14 || o_c !== 1'b0) begin n_fail++; $display("FAIL sub2 got res=%0d c=%b exp res=14 c=0", o_res, o_c); end
        issue(9'b001_11_00_00);  // SUB r3=r0-r0
        n_cmp++; if (o_res !== 4'd0 || o_z !== 1'b1 || o_c !== 1'b1) begin n_fail++; $display("FAIL sub3 got res=%0d z=%b c=%b exp 0 1 1", o_res, o_z, o_c); end
        issue(9'b101_00_1001);   // LDI r0=9
        issue(9'b101_01_1000);   // LDI r1=8
        issue(9'b000_10_00_01);  // ADD -> 17
        n_cmp++; if (o_res !== 4'd1 || o_c !== 1'b1) begin n_fail++; $display("FAIL add_carry got res=%0d c=%b exp res=1 c=1", o_res, o_c); end
        issue(9'b010_10_00_01);  // AND
        n_cmp++; if (o_res !== 4'd8 || o_c !== 1'b1) begin n_fail++; $display("FAIL and got res=%0d c=%b exp res=8 c=1", o_res, o_c); end
        issue(9'b100_10_00_11);  // NOT r2=~r0
        n_cmp++; if (o_res !== 4'd6 || o_b !== 4'd0 || o_f !== 3'b100) begin n_fail++; $display("FAIL not got res=%0d b=%0d f=%b exp 6 0 100", o_res, o_b, o_f); end
`ifdef ALU_OVF_FLAG_EN
        issue(9'b101_00_0111);   // LDI r0=7
        issue(9'b101_01_0001);   // LDI r1=1
        issue(9'b000_10_00_01);  // ADD 7+1
        n_cmp++; if (o_v !== 1'b1) begin n_fail++; $display("FAIL ovf_add got=%b exp=1", o_v); end
        issue(9'b101_00_0110);   // LDI r0=6
        issue(9'b101_01_0100);   // LDI r1=4
        issue(9'b001_10_00_01);  // SUB 6-4
        n_cmp++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL ovf_sub got=%b exp=0", o_v); end
`endif
    endtask

    task automatic test_reserved();
        logic [3:0] prev_res;
        logic       prev_c, prev_z;
        prev_res = res; prev_c = c_flag; prev_z = z_flag;
        for (int k = 0; k < 2; k++) begin
            issue(k == 0 ? 9'b110_01_10_11 : 9'b111_10_01_00);
            n_cmp++; if (o_err !== 1'b1 || o_rv !== 1'b0 || o_err_after !== 1'b0) begin n_fail++; $display("FAIL rsv_pulse got err=%b rv=%b err_after=%b exp 1 0 0", o_err, o_rv, o_err_after); end
            n_cmp++; if (o_res !== prev_res || o_c !== prev_c || o_z !== prev_z) begin n_fail++; $display("FAIL rsv_state got res=%0d c=%b z=%b exp %0d %b %b", o_res, o_c, o_z, prev_res, prev_c, prev_z); end
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            n_cmp++; if (dbg_data !== m_rf[i]) begin n_fail++; $display("FAIL rsv_reg%0d got=%0d exp=%0d", i, dbg_data, m_rf[i]); end
        end
    endtask

    task automatic test_back_to_back();
        model_exec(9'b101_00_0011);
        model_exec(9'b101_01_0101);
        instr_valid = 1'b1; instr = 9'b101_00_0011;      // LDI r0=3 accepted
        @(posedge clk); #1;
        instr = 9'b101_01_0101;                           // LDI r1=5 held during ISSUE/WB
        @(posedge clk); #1;
        n_cmp++; if (instr_ready !== 1'b0 || res !== 4'd3) begin n_fail++; $display("FAIL hold_wb got ready=%b res=%0d exp 0 3", instr_ready, res); end
        @(posedge clk); #1;
        n_cmp++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL hold_idle got ready=%b exp=1", instr_ready); end
        @(posedge clk); #1;
        n_cmp++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL hold_issue got ready=%b exp=0", instr_ready); end
        instr_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (res_valid !== 1'b1 || res !== 4'd5) begin n_fail++; $display("FAIL hold_wb2 got rv=%b res=%0d exp 1 5", res_valid, res); end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            dbg_sel = 2'(i); #1;
            n_cmp++; if (dbg_data !== m_rf[i]) begin n_fail++; $display("FAIL hold_reg%0d got=%0d exp=%0d", i, dbg_data, m_rf[i]); end
        end
    endtask

    task automatic test_reset_mid();
        issue(9'b101_00_1001);   // LDI r0=9
        issue(9'b101_01_1000);   // LDI r1=8
        instr_valid = 1'b1; instr = 9'b000_10_00_01;    // ADD r2 -> carry
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;                                    // reset during WB
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        n_cmp++; if ({instr_ready, res_valid, c_flag, z_flag} !== 4'b1000 || res !== 4'd0) begin n_fail++; $display("FAIL rstmid_state got rdy/rv/c/z=%b res=%0d exp 1000 0", {instr_ready, res_valid, c_flag, z_flag}, res); end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            n_cmp++; if (dbg_data !== 4'd0) begin n_fail++; $display("FAIL rstmid_reg%0d got=%0d exp=0", i, dbg_data); end
        end
    endtask

    task automatic test_random();
        logic [8:0] ins;
        for (int n = 0; n < 60; n++) begin
            ins = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0) ins[8:6] = 3'b101;
            issue(ins);
            n_cmp++; if (o_f !== exp_f || o_a !== exp_a || o_b !== exp_b) begin n_fail++; $display("FAIL rnd_bus ins=%b got f=%b a=%0d b=%0d exp f=%b a=%0d b=%0d", ins, o_f, o_a, o_b, exp_f, exp_a, exp_b); end
            n_cmp++; if (o_res !== exp_res || o_rv !== exp_rv || o_err !== exp_err) begin n_fail++; $display("FAIL rnd_res ins=%b got res=%0d rv=%b err=%b exp %0d %b %b", ins, o_res, o_rv, o_err, exp_res, exp_rv, exp_err); end
            n_cmp++; if (o_c !== m_c || o_z !== m_z) begin n_fail++; $display("FAIL rnd_flags ins=%b got c=%b z=%b exp c=%b z=%b", ins, o_c, o_z, m_c, m_z); end
            n_cmp++; if ({o_ready_issue, o_ready_wb, o_ready_idle, o_rv_after, o_err_after} !== 5'b00100) begin n_fail++; $display("FAIL rnd_timing got=%b exp=00100", {o_ready_issue, o_ready_wb, o_ready_idle, o_rv_after, o_err_after}); end
`ifdef ALU_OVF_FLAG_EN
            n_cmp++; if (o_v !== m_v) begin n_fail++; $display("FAIL rnd_ovf ins=%b got=%b exp=%b", ins, o_v, m_v); end
`endif
            for (int i = 0; i < 4; i++) begin
                dbg_sel = 2'(i); #1;
                n_cmp++; if (dbg_data !== m_rf[i]) begin n_fail++; $display("FAIL rnd_reg%0d got=%0d exp=%0d", i, dbg_data, m_rf[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing stage that wraps the 4-bit combinational ALU (add/sub/and/or/not, 3-bit select f2..f0).
- Accepts encoded instructions over a valid/ready handshake.
- Reads operands from a 4-entry x 4-bit register file and drives the ALU select and operand buses.
- Captures the ALU result and carry-out, writes the result back, and maintains carry/zero status flags.
- Feeds the ALU directly and consumes what it produces; one instruction in flight at a time.

Parameters:
- NREG, 4, register file depth; fixed at 4 because register indices are 2 bits.
- W, 4, datapath width; must match the ALU width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr  in  9  [8:6]=op, [5:4]=rd, [3:2]=ra, [1:0]=rb; for LDI, imm=[3:0]
- f2,f1,f0  out  1 each  ALU operation select
- a  out  W  ALU operand A
- b  out  W  ALU operand B
- fBit  in  W  ALU result
- cout  in  1  ALU adder carry-out
- res_valid  out  1  one-cycle pulse: writeback done
- res  out  W  last written value
- c_flag  out  1  carry flag
- z_flag  out  1  zero flag
- err  out  1  one-cycle pulse: reserved opcode
- dbg_sel  in  2  register file read-port select
- dbg_data  out  W  regfile[dbg_sel], combinational

Behaviour:
- Op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT (a only), 101 LDI, 110/111 reserved.
- Reset (rst_n=0 at an edge): state=IDLE; all regs, res, c_flag and z_flag cleared; res_valid=0, err=0; f=000, a=b=0.
- Reset wins over everything. An in-flight instruction is discarded with no writeback and no flag change.
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - instr_ready=1; f=000, a=b=0.
  - On instr_valid&instr_ready, latch instr and go to ISSUE.
- ISSUE (one cycle):
  - instr_ready=0.
  - f2..f0 = op; a=regfile[ra]; b=regfile[rb]. For NOT, b=0.
  - LDI and reserved ops keep f=000, a=b=0.
  - At the closing edge, sample fBit and cout, then go to WB.
- WB (one cycle), instr_ready=0:
  - ADD/SUB: regfile[rd]=fBit; res=fBit; c_flag=cout (SUB: 1 means no borrow); z_flag=(fBit==0).
  - AND/OR/NOT: write as above; c_flag unchanged; z updated.
  - LDI: regfile[rd]=imm; z updated; c unchanged.
  - For all of the above, res_valid=1 for this cycle only.
  - Reserved: no write, flags and res unchanged, err=1 for one cycle, res_valid=0.
  - Next state is IDLE.
- Throughput: one instruction per 3 cycles. Handshake at edge k gives ISSUE in k+1, WB in k+2, and instr_ready=1 again in k+3.
- Operands are read in ISSUE, before the write. rd==ra or rd==rb uses the old value.
- instr_valid asserted while instr_ready=0 is ignored; the producer must hold it.
- Arithmetic wraps modulo 2^W; the carry is reported only through c_flag.
- The dbg port reflects a write from the edge after WB.

Optional Feature:
- Macro ALU_OVF_FLAG_EN.
- When defined: adds output v_flag (1 bit, reset 0).
- On ADD/SUB writeback, v_flag = signed two's-complement overflow, computed from a, b-effective (~b for SUB) and fBit sign bits. Other ops leave it unchanged.
- When undefined: no port, no logic.

Test Plan:
- Reset then idle: dbg_data=0 for sel 0..3; c=z=0; instr_ready=1; f=000.
- LDI r0=6, LDI r1=4, ADD r2=r0+r1 -> f=000, a=6, b=4 in ISSUE; WB res=10 (1010), c=0, z=0, res_valid 1 cycle; ready returns 3 cycles after accept.
- SUB r3=r0-r1 -> f=001, res=2, c=1. Then SUB r3=r1-r0 -> res=14, c=0. Then SUB r3=r0-r0 -> res=0, z=1, c=1.
- LDI r0=9, LDI r1=8, ADD -> res=1, c=1. Then AND r2=r0&r1 -> res=8, c stays 1. NOT r2=~r0 -> res=6.
- Op 110 -> err pulse, no regfile change, res_valid=0. instr_valid held during ISSUE/WB is accepted only at the next IDLE.
- rst_n low during WB of ADD -> no write; all regs 0, flags 0. With ALU_OVF_FLAG_EN: 7+1 -> v=1; 6-4 -> v=0.
